// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter: circular buffer plus a send FSM that hands one byte at a time to the transmitter.
// Latency: a write into an empty queue with the FSM idle gives tx_send 2 cycles after the wr_en cycle.
// Backpressure: writes made while full are dropped. The FSM waits for tx_busy to rise and then fall before the next pop.
//   If tx_busy never rises within BUSY_TIMEOUT cycles, the byte is treated as sent.
// Ports: clk/rst (synchronous, active-high); wr_en/wr_data write side; full/empty/count status;
//        tx_busy from the transmitter; tx_send/tx_din registered to the transmitter.
// Optional: define UART_TX_QUEUE_OVF_EN to add a sticky 'overflow' output flagging dropped writes.
module uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   tx_busy,
  output logic                   tx_send,
  output logic [7:0]             tx_din
`ifdef UART_TX_QUEUE_OVF_EN
  ,
  output logic                   overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;
  logic [TW-1:0] tmr_q;
  logic          tx_send_q;
  logic [7:0]    tx_din_q;
  logic          wr_fire;
  logic          pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign tx_send = tx_send_q;
  assign tx_din  = tx_din_q;

  // Acceptance depends only on the registered full flag. A pop in the same cycle does not make room for the write.
  assign wr_fire = wr_en & ~full;
  assign pop     = (state_q == IDLE) && (count_q != '0);

  // Pointers are exactly AW bits wide with DEPTH a power of two, so they wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_fire);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    unique case ({wr_fire, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset. Pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Send FSM. tx_send_q is set together with the move into ISSUE, so it is high only for the ISSUE cycle.
  // tx_din_q is only loaded on a pop, which keeps it stable between sends.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      tx_send_q <= 1'b0;
      tx_din_q  <= 8'h00;
    end else begin
      tx_send_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            tx_din_q  <= mem_q[rd_ptr_q];
            tx_send_q <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          tmr_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A transmitter that never reports busy must not stall the queue.
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (tmr_q == TW'(BUSY_TIMEOUT - 1)) begin
            state_q <= IDLE;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_QUEUE_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (wr_en && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed scenarios followed by a randomized run.
// Latency: a monitor checks every cycle against a queue-based reference model.
// Backpressure: a transmitter model drives tx_busy, with fixed, held-low, held-high or random busy lengths.
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int BT    = 4;

  logic                   clk;
  logic                   rst;
  logic                   wr_en;
  logic [7:0]             wr_data;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   tx_busy;
  logic                   tx_send;
  logic [7:0]             tx_din;
`ifdef UART_TX_QUEUE_OVF_EN
  logic                   overflow;
`endif

  int total = 0;
  int bad   = 0;
  int busy_mode;   // 0: held low, 1: high for 10 cycles starting 1 cycle after a send, 2: held high, 3: random length
  int cyc       = 0;
  int send_cnt  = 0;
  logic [7:0] sb[$];          // bytes accepted but not yet sent
  logic [7:0] sent_log[$];
  int         send_cyc[$];
  int         cnt_m;
  logic [7:0] din_m;
  logic       ovf_m;

  uart_tx_queue #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count),
    .tx_busy(tx_busy), .tx_send(tx_send), .tx_din(tx_din)
`ifdef UART_TX_QUEUE_OVF_EN
    , .overflow(overflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model. It updates tx_busy 2 time units after each rising edge.
  initial begin : busy_model
    bit pend;
    int rem;
    tx_busy = 1'b0;
    pend = 1'b0;
    rem = 0;
    forever begin
      @(posedge clk);
      #2;
      case (busy_mode)
        0: begin tx_busy = 1'b0; pend = 1'b0; rem = 0; end
        2: begin tx_busy = 1'b1; pend = 1'b0; rem = 0; end
        default: begin
          if (pend) begin
            pend = 1'b0;
            rem = (busy_mode == 1) ? 10 : int'($urandom_range(0, 4));
          end
          tx_busy = (rem > 0);
          if (rem > 0) rem--;
          if (tx_send === 1'b1) pend = 1'b1;
        end
      endcase
    end
  end

  // Reference model: inputs are captured at the rising edge and outputs are checked at the falling edge.
  initial begin : monitor
    bit s_w, s_r, acc, pop, prev_send;
    logic [7:0] s_d;
    cnt_m = 0;
    din_m = 8'h00;
    ovf_m = 1'b0;
    prev_send = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      s_w = (wr_en === 1'b1);
      s_r = (rst === 1'b1);
      s_d = wr_data;
      @(negedge clk);
      if (s_r) begin
        sb.delete();
        cnt_m = 0;
        din_m = 8'h00;
        ovf_m = 1'b0;
        prev_send = 1'b0;
        chk("rst_tx_send", 32'(tx_send), 0);
      end else begin
        if (s_w && cnt_m == DEPTH) ovf_m = 1'b1;
        acc = s_w && (cnt_m < DEPTH);
        pop = (tx_send === 1'b1);
        if (pop) begin
          chk("pop_nonempty", 32'(cnt_m != 0), 1);
          if (sb.size() > 0) din_m = sb.pop_front();
          send_cnt++;
          send_cyc.push_back(cyc);
          sent_log.push_back(tx_din);
        end
        if (acc) sb.push_back(s_d);
        cnt_m = cnt_m + int'(acc) - ((pop && cnt_m > 0) ? 1 : 0);
        chk("no_back2back", 32'(prev_send & pop), 0);
        prev_send = pop;
      end
      chk("count", 32'(count), 32'(cnt_m));
      chk("empty", 32'(empty), 32'(cnt_m == 0));
      chk("full", 32'(full), 32'(cnt_m == DEPTH));
      chk("tx_din", 32'(tx_din), 32'(din_m));
`ifdef UART_TX_QUEUE_OVF_EN
      chk("overflow", 32'(overflow), 32'(ovf_m));
`endif
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget && (sb.size() != 0 || count != 0); i++) step();
    repeat (16) step();
    chk("drain_model_empty", 32'(sb.size()), 0);
    chk("drain_count", 32'(count), 0);
  endtask

  initial begin : main
    int base;
    int pct;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    busy_mode = 0;
    repeat (3) step();
    chk("reset_count", 32'(count), 0);
    chk("reset_empty", 32'(empty), 1);
    chk("reset_full", 32'(full), 0);
    chk("reset_send", 32'(tx_send), 0);
    chk("reset_din", 32'(tx_din), 0);
    rst = 1'b0;
    busy_mode = 1;
    step();

    // Single byte: send 2 cycles after the write cycle.
    sent_log.delete();
    wr_en = 1'b1;
    wr_data = 8'h41;
    step();
    wr_en = 1'b0;
    chk("lat_no_early_send", 32'(tx_send), 0);
    chk("lat_count1", 32'(count), 1);
    step();
    chk("lat_send", 32'(tx_send), 1);
    chk("lat_din", 32'(tx_din), 32'h41);
    repeat (15) step();
    chk("s1_count0", 32'(count), 0);
    chk("s1_one_send", 32'(sent_log.size()), 1);

    // Transmitter never reports busy: each send is released by the timeout.
    busy_mode = 0;
    step();
    send_cyc.delete();
    wr(8'h01);
    wr(8'h02);
    for (int i = 0; i < 40 && send_cyc.size() < 2; i++) step();
    chk("timeout_two_sends", 32'(send_cyc.size()), 2);
    if (send_cyc.size() >= 2) chk("timeout_spacing", 32'(send_cyc[1] - send_cyc[0]), 32'(2 + BT));
    drain(100);

    // Burst until full while the transmitter is held busy, then one dropped write.
    busy_mode = 2;
    step();
    sent_log.delete();
    for (int i = 0; i < 17; i++) wr(8'(8'h30 + i));
    step();
    chk("burst_count16", 32'(count), 16);
    chk("burst_full", 32'(full), 1);
    wr(8'h55);
    step();
    chk("drop_count16", 32'(count), 16);
    busy_mode = 1;
    drain(600);
    chk("burst_nsent", 32'(sent_log.size()), 17);
    for (int i = 0; i < 17; i++)
      if (i < sent_log.size()) chk("burst_order", 32'(sent_log[i]), 32'(8'h30 + i));
`ifdef UART_TX_QUEUE_OVF_EN
    chk("ovf_sticky", 32'(overflow), 1);
`endif

    // A write and a pop in the same cycle at count 5.
    busy_mode = 2;
    step();
    for (int i = 0; i < 6; i++) wr(8'(8'h60 + i));
    repeat (4) step();
    chk("c5_setup", 32'(count), 5);
    busy_mode = 0;
    step();
    step();
    wr_en = 1'b1;
    wr_data = 8'h99;
    step();
    wr_en = 1'b0;
    chk("c5_pop", 32'(tx_send), 1);
    chk("c5_count", 32'(count), 5);
    drain(300);

    // Reset while a byte is in WAIT_DONE.
    busy_mode = 2;
    step();
    wr(8'h70);
    wr(8'h71);
    wr(8'h72);
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_send", 32'(tx_send), 0);
    rst = 1'b0;
    base = send_cnt;
    repeat (20) step();
    chk("mid_rst_no_sends", 32'(send_cnt - base), 0);
    chk("mid_rst_count_after", 32'(count), 0);
`ifdef UART_TX_QUEUE_OVF_EN
    chk("ovf_cleared", 32'(overflow), 0);
`endif

    // Random traffic with random busy lengths. The heavy early phase forces the queue full and drops writes.
    busy_mode = 3;
    for (int i = 0; i < 1500; i++) begin
      pct = (i < 600) ? 80 : 25;
      wr_en = ($urandom_range(0, 99) < pct);
      wr_data = 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
